// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (default priority) and a host/debug port.
// Optional feature macro DMEM_ARB_STATS_EN adds a saturating CPU stall counter (stall_count, stats_clr).
module dmem_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef DMEM_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       stall_count,
`endif
  output logic [1:0]        dbg_state
);

  // Handshake: the host holds req/we/addr/wdata stable until host_gnt; the access happens in the
  // grant cycle, and a granted read returns host_rdata with a one-cycle host_rvalid pulse next cycle.
  // dbg_state encoding: 0 = IDLE, 1 = CPU_OWN, 2 = HOST_OWN.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_OWN  = 2'd1,
    HOST_OWN = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_wait_cnt;
  logic [3:0]        w_wait_nxt;
  logic [3:0]        r_burst_cnt;
  logic [3:0]        w_burst_nxt;
  logic              r_host_rvalid;
  logic [DATA_W-1:0] r_host_rdata;
  logic              w_host_win;
  logic              w_cpu_win;

  always_comb begin
    w_host_win = host_req & ((r_state == HOST_OWN) | ~cpu_req | (r_wait_cnt == WAIT_LIMIT));
    w_cpu_win  = cpu_req & ~w_host_win;
    // Everything combinational is held at zero while reset is asserted.
    host_gnt   = rst & w_host_win;
    cpu_stall  = rst & cpu_req & w_host_win;
    mem_en     = rst & (w_host_win | w_cpu_win);
    mem_we     = rst & (w_host_win ? host_we : (w_cpu_win & cpu_we));
    mem_addr   = '0;
    mem_wdata  = '0;
    if (rst) begin
      mem_addr  = w_host_win ? host_addr  : cpu_addr;
      mem_wdata = w_host_win ? host_wdata : cpu_wdata;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    w_burst_nxt = '0;
    w_wait_nxt  = '0;
    if (host_req & ~w_host_win) begin
      w_wait_nxt = (r_wait_cnt == WAIT_LIMIT) ? r_wait_cnt : r_wait_cnt + 4'd1;
    end
    if (w_host_win) begin
      // burst_cnt is zero outside HOST_OWN, so entry and continuation share one path;
      // the grant that completes BURST_MAX locked grants hands ownership back to the CPU.
      if (host_lock) begin
        if (r_burst_cnt >= BURST_LAST) begin
          w_state_nxt = CPU_OWN;
        end else begin
          w_state_nxt = HOST_OWN;
          w_burst_nxt = r_burst_cnt + 4'd1;
        end
      end
    end else if (w_cpu_win) begin
      w_state_nxt = CPU_OWN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_wait_cnt    <= '0;
      r_burst_cnt   <= '0;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_burst_cnt   <= w_burst_nxt;
      r_host_rvalid <= w_host_win & ~host_we;
      if (w_host_win & ~host_we) begin
        r_host_rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
    end else if (stats_clr) begin
      r_stall_count <= '0;
    end else if (cpu_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

  assign cpu_rdata   = mem_rdata;
  assign host_rvalid = r_host_rvalid;
  assign host_rdata  = r_host_rdata;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a grant-rule model.
// Covers the DMEM_ARB_STATS_EN counter when that macro is defined.
module tb_dmem_arbiter;
  localparam int MAX_WAIT  = 4;
  localparam int BURST_MAX = 4;

  logic       clk;
  logic       rst;
  logic       cpu_req, cpu_we;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       cpu_stall;
  logic       host_req, host_we, host_lock;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic       mem_en, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [1:0] dbg_state;
`ifdef DMEM_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] stall_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tb_mem  [16];
  logic [7:0] exp_mem [16];
  logic [7:0] exp_q [$];

  dmem_arbiter #(
    .ADDR_W(4), .DATA_W(8), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef DMEM_ARB_STATS_EN
    .stats_clr(stats_clr), .stall_count(stall_count),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / memory behind the arbiter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = tb_mem[mem_addr];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Driver tasks
  task automatic drive_idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_lock = 0; host_addr = '0; host_wdata = '0;
`ifdef DMEM_ARB_STATS_EN
    stats_clr = 0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'd5; cpu_wdata = 8'hFF;
    host_req = 1; host_we = 1; host_addr = 4'd9; host_wdata = 8'h77;
    rst = 0;
    #1;
    n_checks++;
    if ({host_gnt, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata, host_rvalid, host_rdata} !== 25'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {host_gnt, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata, host_rvalid, host_rdata});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({dbg_state, mem_en, host_gnt, host_rvalid} !== 5'd0) begin
      n_errors++;
      $display("FAIL reset_held: got state=%0d en=%b gnt=%b rv=%b expected all 0",
               dbg_state, mem_en, host_gnt, host_rvalid);
    end
    @(negedge clk);
    drive_idle();
    rst = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({dbg_state, mem_en, host_rvalid} !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_release_idle: got state=%0d en=%b rv=%b expected 0", dbg_state, mem_en, host_rvalid);
    end
  endtask

  task automatic test_cpu_only();
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'd3; cpu_wdata = 8'hA5;
    #1;
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_stall, host_gnt} !== {1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL cpu_write: got en=%b we=%b addr=%h wd=%h stall=%b gnt=%b expected 1 1 3 a5 0 0",
               mem_en, mem_we, mem_addr, mem_wdata, cpu_stall, host_gnt);
    end
    @(negedge clk);
    cpu_we = 0; cpu_wdata = 8'h00;
    #1;
    n_checks++;
    if ({mem_en, mem_we, mem_addr, cpu_rdata, cpu_stall, host_gnt} !== {1'b1, 1'b0, 4'd3, 8'hA5, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL cpu_read: got en=%b we=%b addr=%h rdata=%h stall=%b gnt=%b expected 1 0 3 a5 0 0",
               mem_en, mem_we, mem_addr, cpu_rdata, cpu_stall, host_gnt);
    end
    @(posedge clk); #1;
    n_checks++;
    if (dbg_state !== 2'd1) begin
      n_errors++;
      $display("FAIL cpu_own_state: got %0d expected 1", dbg_state);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_host_only();
    do_reset();
    host_req = 1; host_we = 1; host_addr = 4'd7; host_wdata = 8'h3C;
    #1;
    n_checks++;
    if ({host_gnt, mem_en, mem_we, mem_addr, mem_wdata, cpu_stall} !== {1'b1, 1'b1, 1'b1, 4'd7, 8'h3C, 1'b0}) begin
      n_errors++;
      $display("FAIL host_write: got gnt=%b en=%b we=%b addr=%h wd=%h stall=%b expected 1 1 1 7 3c 0",
               host_gnt, mem_en, mem_we, mem_addr, mem_wdata, cpu_stall);
    end
    @(posedge clk); #1;
    n_checks++;
    if (host_rvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL host_write_no_rvalid: got %b expected 0", host_rvalid);
    end
    @(negedge clk);
    host_we = 0; host_wdata = 8'h00;
    #1;
    n_checks++;
    if ({host_gnt, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 4'd7}) begin
      n_errors++;
      $display("FAIL host_read_gnt: got gnt=%b en=%b we=%b addr=%h expected 1 1 0 7",
               host_gnt, mem_en, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({host_rvalid, host_rdata} !== {1'b1, 8'h3C}) begin
      n_errors++;
      $display("FAIL host_read_data: got rv=%b rdata=%h expected 1 3c", host_rvalid, host_rdata);
    end
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    n_checks++;
    if ({host_rvalid, host_gnt, dbg_state} !== 4'd0) begin
      n_errors++;
      $display("FAIL host_rvalid_pulse: got rv=%b gnt=%b state=%0d expected 0 0 0", host_rvalid, host_gnt, dbg_state);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    bit exp_h;
    do_reset();
    cpu_req = 1; cpu_we = 0; host_req = 1; host_we = 0; host_lock = 0; host_addr = 4'd4;
    for (int c = 0; c < 15; c++) begin
      cpu_addr = 4'($urandom_range(0, 15));
      exp_h = ((c % (MAX_WAIT + 1)) == MAX_WAIT);
      #1;
      n_checks++;
      if ({host_gnt, cpu_stall, mem_en, mem_addr} !== {exp_h, exp_h, 1'b1, (exp_h ? 4'd4 : cpu_addr)}) begin
        n_errors++;
        $display("FAIL contention_c%0d: got gnt=%b stall=%b en=%b addr=%h expected %b %b 1 %h", c,
                 host_gnt, cpu_stall, mem_en, mem_addr, exp_h, exp_h, (exp_h ? 4'd4 : cpu_addr));
      end
      @(posedge clk); #1;
      n_checks++;
      if (host_rvalid !== exp_h) begin
        n_errors++;
        $display("FAIL contention_rvalid_c%0d: got %b expected %b", c, host_rvalid, exp_h);
      end
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic test_burst();
    bit exp_h;
    logic [1:0] exp_st;
    do_reset();
    cpu_req = 1; cpu_we = 0; host_req = 1; host_we = 0; host_lock = 1; host_addr = 4'd1;
    // MAX_WAIT CPU grants, then BURST_MAX locked host grants, then the CPU again
    for (int c = 0; c < 2 * (MAX_WAIT + BURST_MAX); c++) begin
      cpu_addr = 4'($urandom_range(0, 15));
      exp_h  = ((c % (MAX_WAIT + BURST_MAX)) >= MAX_WAIT);
      exp_st = (exp_h && ((c % (MAX_WAIT + BURST_MAX)) < MAX_WAIT + BURST_MAX - 1)) ? 2'd2 : 2'd1;
      #1;
      n_checks++;
      if ({host_gnt, cpu_stall} !== {exp_h, exp_h}) begin
        n_errors++;
        $display("FAIL burst_c%0d: got gnt=%b stall=%b expected %b %b", c, host_gnt, cpu_stall, exp_h, exp_h);
      end
      @(posedge clk); #1;
      n_checks++;
      if (dbg_state !== exp_st) begin
        n_errors++;
        $display("FAIL burst_state_c%0d: got %0d expected %0d", c, dbg_state, exp_st);
      end
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    host_req = 1; host_we = 0; host_lock = 1; host_addr = 4'd2;
    #1;
    n_checks++;
    if (host_gnt !== 1'b1) begin
      n_errors++;
      $display("FAIL midburst_grant1: got %b expected 1", host_gnt);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({host_gnt, host_rvalid, dbg_state} !== {1'b1, 1'b1, 2'd2}) begin
      n_errors++;
      $display("FAIL midburst_grant2: got gnt=%b rv=%b state=%0d expected 1 1 2", host_gnt, host_rvalid, dbg_state);
    end
    rst = 0;
    #1;
    n_checks++;
    if ({host_gnt, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata, host_rvalid, host_rdata} !== 25'd0) begin
      n_errors++;
      $display("FAIL midburst_reset_outputs: got %h expected 0",
               {host_gnt, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata, host_rvalid, host_rdata});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({host_rvalid, dbg_state} !== 3'd0) begin
      n_errors++;
      $display("FAIL midburst_after_edge: got rv=%b state=%0d expected 0 0", host_rvalid, dbg_state);
    end
    @(negedge clk);
    rst = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd6;
    #1;
    n_checks++;
    if ({host_gnt, cpu_stall, mem_en, mem_addr} !== {1'b0, 1'b0, 1'b1, 4'd6}) begin
      n_errors++;
      $display("FAIL midburst_cpu_first: got gnt=%b stall=%b en=%b addr=%h expected 0 0 1 6",
               host_gnt, cpu_stall, mem_en, mem_addr);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({host_rvalid, dbg_state} !== {1'b0, 2'd1}) begin
      n_errors++;
      $display("FAIL midburst_post_state: got rv=%b state=%0d expected 0 1", host_rvalid, dbg_state);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_random();
    bit h_pend, hw, cw, exp_rv;
    logic h_we;
    logic [3:0] h_addr, exp_addr;
    logic [7:0] h_wdata, exp_wdata, exp_rd;
    int m_wait, m_burst;
    do_reset();
    exp_q.delete();
    for (int a = 0; a < 16; a++) begin
      host_req = 1; host_we = 1; host_addr = a[3:0]; host_wdata = 8'($urandom);
      exp_mem[a] = host_wdata;
      @(negedge clk);
    end
    drive_idle();
    m_wait = 0; m_burst = 0; h_pend = 0;
    h_we = 0; h_addr = '0; h_wdata = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!h_pend && $urandom_range(0, 2) != 0) begin
        h_pend = 1; h_we = 1'($urandom_range(0, 1));
        h_addr = 4'($urandom_range(0, 15)); h_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 7) == 0) host_lock = ~host_lock;
      host_req = h_pend; host_we = h_we; host_addr = h_addr; host_wdata = h_wdata;
      cpu_req = ($urandom_range(0, 3) != 0); cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 4'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
      #1;
      // Grant decision straight from the priority rules
      hw = h_pend && (m_burst > 0 || !cpu_req || m_wait >= MAX_WAIT);
      cw = cpu_req && !hw;
      exp_addr  = hw ? h_addr : cpu_addr;
      exp_wdata = hw ? h_wdata : cpu_wdata;
      n_checks++;
      if ({host_gnt, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata} !==
          {hw, cpu_req && hw, hw || cw, hw ? h_we : (cw && cpu_we), exp_addr, exp_wdata}) begin
        n_errors++;
        $display("FAIL random_mux_c%0d: got gnt=%b stall=%b en=%b we=%b addr=%h wd=%h expected %b %b %b %b %h %h",
                 c, host_gnt, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata,
                 hw, cpu_req && hw, hw || cw, hw ? h_we : (cw && cpu_we), exp_addr, exp_wdata);
      end
      if (cw && !cpu_we) begin
        n_checks++;
        if (cpu_rdata !== exp_mem[cpu_addr]) begin
          n_errors++;
          $display("FAIL random_cpu_read_c%0d: got %h expected %h", c, cpu_rdata, exp_mem[cpu_addr]);
        end
      end
      exp_rv = hw && !h_we;
      if (hw) begin
        if (h_we) exp_mem[h_addr] = h_wdata;
        else exp_q.push_back(exp_mem[h_addr]);
      end
      if (cw && cpu_we) exp_mem[cpu_addr] = cpu_wdata;
      if (hw) begin
        m_wait = 0;
        m_burst = host_lock ? m_burst + 1 : 0;
        if (m_burst >= BURST_MAX) m_burst = 0;
        h_pend = 0;
      end else begin
        m_wait = h_pend ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
        m_burst = 0;
      end
      @(posedge clk); #1;
      n_checks++;
      if (host_rvalid !== exp_rv) begin
        n_errors++;
        $display("FAIL random_rvalid_c%0d: got %b expected %b", c, host_rvalid, exp_rv);
      end
      if (exp_rv) begin
        exp_rd = exp_q.pop_front();
        n_checks++;
        if (host_rdata !== exp_rd) begin
          n_errors++;
          $display("FAIL random_host_rdata_c%0d: got %h expected %h", c, host_rdata, exp_rd);
        end
      end
      @(negedge clk);
    end
    drive_idle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL random_queue_drain: got %0d entries left expected 0", exp_q.size());
    end
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    cpu_req = 1; host_req = 1; host_addr = 4'd8;
    for (int c = 0; c < 25; c++) begin
      stats_clr = (c == 24);
      @(posedge clk); #1;
      if (c == 19) begin
        n_checks++;
        if (stall_count !== 16'd4) begin
          n_errors++;
          $display("FAIL stats_count: got %0d expected 4", stall_count);
        end
      end
      if (c == 24) begin
        n_checks++;
        if (stall_count !== 16'd0) begin
          n_errors++;
          $display("FAIL stats_clear_priority: got %0d expected 0", stall_count);
        end
      end
      @(negedge clk);
    end
    drive_idle();
  endtask
`endif

  initial begin
    rst = 0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1;
    test_reset();
    test_cpu_only();
    test_host_only();
    test_contention();
    test_burst();
    test_reset_mid_burst();
    test_random();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
